// File: rtl/axi_hp_wr_arbiter_if.sv
// axi_hp_wr_arbiter_if: AXI3 write-channel bundle (AW/W/B) between the arbiter and the HP slave port
interface axi_hp_wr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_hp_wr_arbiter.sv
// axi_hp_wr_arbiter: round-robin sharing of one AXI3 HP write port, one burst outstanding.
// Defining AXI_HP_ARB_STAT_EN adds per-requester accepted-beat counters (stat_beats, stat_clr).
module axi_hp_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*4-1:0]        req_len,
    output logic [N_REQ-1:0]          gnt,
    input  logic [N_REQ*DATA_W-1:0]   src_wdata,
    input  logic [N_REQ-1:0]          src_wvalid,
    output logic [N_REQ-1:0]          src_wready,
    output logic [N_REQ-1:0]          done,
    output logic                      done_err,
`ifdef AXI_HP_ARB_STAT_EN
    input  logic                      stat_clr,
    output logic [N_REQ*32-1:0]       stat_beats,
`endif
    axi_hp_wr_arbiter_if.master       axi
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
    state_t state, state_nx;
    logic [IW-1:0] ptr, gidx, win;
    logic [IW:0] j;
    logic found, w_hs;
    logic [ADDR_W-1:0] awaddr_q;
    logic [3:0] awlen_q, cnt;
    // first requesting slot at or after ptr, wrapping
    always_comb begin
        win = '0;
        found = 1'b0;
        j = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
            if (!found && req[j[IW-1:0]]) begin
                win = j[IW-1:0];
                found = 1'b1;
            end
        end
    end
    assign w_hs         = state == W && axi.wvalid && axi.wready;
    assign axi.awaddr   = awaddr_q;
    assign axi.awlen    = awlen_q;
    assign axi.awsize   = 3'($clog2(DATA_W/8));
    assign axi.awburst  = 2'b01;
    assign axi.wstrb    = '1;
    always_comb begin
        state_nx    = state;
        axi.awvalid = state == AW;
        axi.wvalid  = state == W && src_wvalid[gidx];
        axi.wdata   = src_wdata[gidx*DATA_W +: DATA_W];
        axi.wlast   = state == W && cnt == awlen_q;
        axi.bready  = state == B;
        src_wready  = state == W && axi.wready ? gnt : '0;
        done        = state == B && axi.bvalid ? gnt : '0;
        done_err    = state == B && axi.bvalid && axi.bresp != 2'b00;
        case (state)
            IDLE: state_nx = found ? AW : IDLE;
            AW:   state_nx = axi.awready ? W : AW;
            W:    state_nx = w_hs && axi.wlast ? B : W;
            B:    state_nx = axi.bvalid ? IDLE : B;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            gnt      <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                gidx     <= win;
                gnt      <= N_REQ'(1) << win;
                awaddr_q <= req_addr[win*ADDR_W +: ADDR_W];
                awlen_q  <= req_len[win*4 +: 4];
            end
            if (state == AW && axi.awready) cnt <= '0;
            if (w_hs) cnt <= cnt + 1'b1;
            if (state == B && axi.bvalid) begin
                gnt <= '0;
                ptr <= gidx == IW'(N_REQ-1) ? '0 : gidx + 1'b1;
            end
        end
    end
`ifdef AXI_HP_ARB_STAT_EN
    logic [31:0] beats [N_REQ];
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst) beats[i] <= '0;
            else if (stat_clr) beats[i] <= '0;
            else if (w_hs && gidx == IW'(i) && beats[i] != '1) beats[i] <= beats[i] + 1'b1;
        end
    end
    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_beats[g*32 +: 32] = beats[g];
    end
`endif
endmodule

// File: tb/tb_axi_hp_wr_arbiter.sv
// tb_axi_hp_wr_arbiter: table vectors, hand sequences and random bursts against a round-robin model.
module tb_axi_hp_wr_arbiter;
    localparam int N = 4, DW = 64, AWD = 32;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] req, gnt, src_wvalid, src_wready, done;
    logic [N*AWD-1:0] req_addr;
    logic [N*4-1:0] req_len;
    logic [N*DW-1:0] src_wdata;
    logic done_err;
`ifdef AXI_HP_ARB_STAT_EN
    logic stat_clr;
    logic [N*32-1:0] stat_beats;
`endif
    axi_hp_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AWD)) axi();
    axi_hp_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AWD)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
        .src_wdata(src_wdata), .src_wvalid(src_wvalid), .src_wready(src_wready),
        .done(done), .done_err(done_err),
`ifdef AXI_HP_ARB_STAT_EN
        .stat_clr(stat_clr), .stat_beats(stat_beats),
`endif
        .axi(axi)
    );
    typedef struct {
        logic [3:0] r;
        logic [3:0] len;
        logic [1:0] br;
        int         dly;
        int         wmode;
        logic [3:0] g;
    } vec_t;
    vec_t tbl[12];
    int n_cmp = 0, n_err = 0, mptr = 0, nburst = 0, cyc, beat;
    logic [31:0] salt;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [63:0] pat(int gi, int b);
        return {8'(gi), 8'(b), 16'(nburst), salt};
    endfunction
    function automatic logic [31:0] addr_of(int i);
        return 32'h1000_0000 + 32'(i) * 32'h1000 + 32'(nburst) * 32'h10;
    endfunction
    // round robin: first requester at or after the pointer, wrapping
    function automatic logic [3:0] rr(logic [3:0] r);
        for (int k = 0; k < N; k++)
            if (r[(mptr + k) % N]) return 4'(1 << ((mptr + k) % N));
        return 4'b0;
    endfunction
    task automatic run_burst(input logic [3:0] r, input logic [3:0] len, input logic [1:0] br,
                             input int dly, input int wmode, input logic [3:0] exp_g);
        int c, gi, b;
        logic [3:0] g;
        @(negedge clk);
        salt = $urandom;
        req = r;
        for (int i = 0; i < N; i++) req_addr[i*AWD +: AWD] = addr_of(i);
        req_len = {N{len}};
        src_wvalid = '1;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        c = 0;
        #1;
        while (!axi.awvalid && c < 20) begin @(negedge clk); #1; c++; end
        chk("aw_latency", 64'(c), 64'd1);
        g = gnt;
        chk("gnt", g, exp_g);
        gi = 0;
        for (int i = 0; i < N; i++) if (exp_g[i]) begin gi = i; mptr = (i + 1) % N; end
        chk("awaddr", axi.awaddr, addr_of(gi));
        chk("awlen", axi.awlen, len);
        chk("awsize_burst", {axi.awsize, axi.awburst}, {3'd3, 2'b01});
        req = req & ~g;
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            axi.bvalid = d == 0;
            req_addr = ~req_addr;
            req_len = ~req_len;
            #1;
            chk("aw_stable", {axi.awvalid, axi.awlen, axi.awaddr}, {1'b1, len, addr_of(gi)});
            if (d == 0) chk("no_early_b", {axi.bready, done}, 0);
        end
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.awready = 1'b1;
        #1;
        chk("wvalid_before_aw", axi.wvalid, 0);
        b = 0; c = 0;
        while (b <= int'(len) && c < 400) begin
            @(negedge clk);
            axi.awready = 1'b0;
            axi.wready = wmode == 0 ? 1'b1 : wmode == 1 ? 1'(c % 2) : 1'($urandom);
            src_wvalid = '1;
            if (wmode == 2) src_wvalid[gi] = 1'($urandom);
            for (int i = 0; i < N; i++) src_wdata[i*DW +: DW] = ~pat(gi, b);
            src_wdata[gi*DW +: DW] = pat(gi, b);
            #1;
            chk("wvalid", axi.wvalid, src_wvalid[gi]);
            chk("src_wready", src_wready, axi.wready ? g : 4'b0);
            if (axi.wvalid && axi.wready) begin
                chk("wdata", axi.wdata, pat(gi, b));
                chk("wlast", axi.wlast, b == int'(len));
                b++;
            end
            c++;
        end
        chk("beats", 64'(b), 64'(len) + 1);
        @(negedge clk);
        axi.wready = 1'b0;
        src_wvalid = '0;
        #1;
        chk("b_wait", {axi.bready, axi.wvalid, gnt, done}, {1'b1, 1'b0, g, 4'b0});
        @(negedge clk);
        axi.bvalid = 1'b1;
        axi.bresp = br;
        req = '0;
        #1;
        chk("done", {done, done_err}, {exp_g, br != 2'b00});
        @(negedge clk);
        axi.bvalid = 1'b0;
        #1;
        chk("done_pulse", {done, done_err, gnt, axi.awvalid, axi.bready}, 0);
        nburst++;
    endtask
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl[0]  = '{4'b0001, 4'd3,  2'b00, 0, 0, 4'b0001};
        tbl[1]  = '{4'b1000, 4'd0,  2'b00, 0, 0, 4'b1000};
        tbl[2]  = '{4'b1010, 4'd1,  2'b00, 0, 0, 4'b0010};
        tbl[3]  = '{4'b1010, 4'd1,  2'b00, 0, 0, 4'b1000};
        tbl[4]  = '{4'b1111, 4'd2,  2'b00, 2, 0, 4'b0001};
        tbl[5]  = '{4'b1111, 4'd0,  2'b00, 0, 0, 4'b0010};
        tbl[6]  = '{4'b1111, 4'd1,  2'b00, 0, 0, 4'b0100};
        tbl[7]  = '{4'b1111, 4'd0,  2'b00, 0, 0, 4'b1000};
        tbl[8]  = '{4'b1111, 4'd0,  2'b00, 0, 0, 4'b0001};
        tbl[9]  = '{4'b0100, 4'd2,  2'b10, 0, 0, 4'b0100};
        tbl[10] = '{4'b0011, 4'd0,  2'b00, 0, 0, 4'b0001};
        tbl[11] = '{4'b0110, 4'd15, 2'b00, 5, 1, 4'b0010};
        req = '0; req_addr = '0; req_len = '0; src_wdata = '0; src_wvalid = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        salt = '0;
`ifdef AXI_HP_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {gnt, done, done_err, src_wready, axi.awvalid, axi.wvalid, axi.wlast,
                            axi.bready, axi.awlen, axi.awaddr}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            run_burst(tbl[i].r, tbl[i].len, tbl[i].br, tbl[i].dly, tbl[i].wmode, tbl[i].g);
        run_burst(4'b0100, 4'd0, 2'b00, 0, 0, 4'b0100);
        // abort a burst after two beats: reset must clear everything at once and zero the pointer
        @(negedge clk);
        req = 4'b0001; req_len = {N{4'd7}}; src_wvalid = '1; axi.awready = 1'b1;
        #1;
        cyc = 0;
        while (!axi.awvalid && cyc < 20) begin @(negedge clk); #1; cyc++; end
        req = '0;
        beat = 0; cyc = 0;
        while (beat < 2 && cyc < 20) begin
            @(negedge clk);
            axi.awready = 1'b0;
            axi.wready = 1'b1;
            #1;
            if (axi.wvalid) beat++;
            cyc++;
        end
        chk("pre_reset_beats", 64'(beat), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mid_w", {gnt, done, done_err, src_wready, axi.awvalid, axi.wvalid, axi.wlast,
                            axi.bready, axi.awlen, axi.awaddr}, 0);
        @(negedge clk);
        axi.wready = 1'b0; src_wvalid = '0;
        rst = 1'b0;
        mptr = 0;
        run_burst(4'b1100, 4'd1, 2'b00, 0, 0, 4'b0100);
        for (int k = 0; k < 40; k++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            run_burst(r, 4'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 2, rr(r));
        end
`ifdef AXI_HP_ARB_STAT_EN
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("stat_clr0", stat_beats, 0);
        for (int k = 0; k < 3; k++) run_burst(4'b0010, 4'd7, 2'b00, 0, 2, rr(4'b0010));
        chk("stat_beats1", stat_beats[32 +: 32], 64'd24);
        chk("stat_other", {stat_beats[0 +: 32], stat_beats[64 +: 64]}, 0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("stat_clr1", stat_beats, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
